// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M shift-add multiplier and restoring divider
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, ADJ = 2'd2, DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  logic [1:0] state;
  logic [2:0] op_q;
  logic neg_q;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] rem, dvs;
  logic sa, sb, neg, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_val, adj_val, quo, rmd;
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    sa = !(op[0] && (op[1] || op[2]));
    sb = op[2] ? !op[0] : !op[1];
    mag_a = (sa && a[XLEN-1]) ? -a : a;
    mag_b = (sb && b[XLEN-1]) ? -b : b;
    neg = (op[2] && op[1]) ? (sa && a[XLEN-1]) : ((sa && a[XLEN-1]) ^ (sb && b[XLEN-1]));
    fast = op[2] && (b == '0 || (!op[0] && a == MIN && b == '1));
    fast_val = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? dvs : {XLEN{1'b0}})};
    div_sh = {rem, acc[XLEN-1]};
    div_diff = div_sh - {1'b0, dvs};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd = neg_q ? -rem : rem;
    adj_val = op_q[2] ? (op_q[1] ? rmd : quo) : ((op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      neg_q <= 1'b0;
      cnt <= '0;
      acc <= '0;
      rem <= '0;
      dvs <= '0;
      result <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          neg_q <= neg;
          cnt <= '0;
          dvs <= mag_b;
          acc <= {{XLEN{1'b0}}, mag_a};
          rem <= '0;
          state <= fast ? DONE : CALC;
          if (fast) result <= fast_val;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= op_q[2] ? {{XLEN{1'b0}}, acc[XLEN-2:0], !div_diff[XLEN]} : {mul_sum, acc[XLEN-1:1]};
          if (op_q[2]) rem <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
          state <= (cnt == LAST) ? ADJ : CALC;
        end
        ADJ: begin
          result <= adj_val;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector, random and corner-sequence checks of muldiv_unit at XLEN 32 and 64
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst, start32, start64, kill;
  logic [2:0] op;
  logic [63:0] a, b;
  logic busy32, done32, busy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a[31:0]), .b(b[31:0]),
    .kill(kill), .busy(busy32), .done(done32), .result(res32)
  );
  muldiv_unit #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy64), .done(done64), .result(res64)
  );
  typedef struct {
    bit w;
    logic [2:0] op;
    logic [63:0] a, b, exp;
    int lat;
  } vec_t;
  vec_t vt[24];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input bit w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    int n;
    logic [63:0] m, xa, yb, minv;
    logic signed [129:0] sx, sy, ux, uy, p;
    logic ovf;
    n = w ? 64 : 32;
    m = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    xa = x & m;
    yb = y & m;
    sx = w ? {{66{x[63]}}, x} : {{98{x[31]}}, x[31:0]};
    sy = w ? {{66{y[63]}}, y} : {{98{y[31]}}, y[31:0]};
    ux = {66'b0, xa};
    uy = {66'b0, yb};
    ovf = (xa == minv) && (yb == m);
    p = '0;
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = (sx * sy) >>> n;
      3'd2: p = (sx * uy) >>> n;
      3'd3: p = (ux * uy) >>> n;
      3'd4: if (yb == 0) p = {66'b0, m}; else if (ovf) p = {66'b0, xa}; else p = sx / sy;
      3'd5: if (yb == 0) p = {66'b0, m}; else p = ux / uy;
      3'd6: if (yb == 0) p = {66'b0, xa}; else if (ovf) p = '0; else p = sx % sy;
      default: if (yb == 0) p = {66'b0, xa}; else p = ux % uy;
    endcase
    return p[63:0] & m;
  endfunction
  function automatic int model_lat(input bit w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m, minv;
    m = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (o[2] && (((y & m) == 0) || (!o[0] && (x & m) == minv && (y & m) == m))) return 1;
    return w ? 66 : 34;
  endfunction
  function automatic logic [63:0] rnd(input bit w);
    logic [63:0] m, v;
    m = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = w ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction
  task automatic run_op(input bit w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] r, output int lat);
    int low;
    low = 0;
    op = o;
    a = x;
    b = y;
    if (w) start64 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    start64 = 1'b0;
    lat = 1;
    while (!(w ? done64 : done32) && lat < 200) begin
      if (!(w ? busy64 : busy32)) low++;
      @(posedge clk); #1;
      lat++;
    end
    if (!(w ? busy64 : busy32)) low++;
    r = w ? res64 : {32'b0, res32};
    chk("busy_during_op", 64'(low), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(w ? done64 : done32), 64'd0);
    chk("idle_after_done", 64'(w ? busy64 : busy32), 64'd0);
  endtask
  initial begin
    logic [63:0] r, x, y;
    logic [2:0] o;
    bit w;
    int lat, seen;
    rst = 1'b1;
    start32 = 1'b0;
    start64 = 1'b0;
    kill = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_res32", {32'b0, res32}, 64'd0);
    chk("rst_busy64", 64'(busy64), 64'd0);
    chk("rst_done64", 64'(done64), 64'd0);
    chk("rst_res64", res64, 64'd0);
    rst = 1'b0;
    vt[0]  = '{0, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 34};
    vt[1]  = '{0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 34};
    vt[2]  = '{0, 3'd3, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 34};
    vt[3]  = '{0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 34};
    vt[4]  = '{0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 34};
    vt[5]  = '{0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34};
    vt[6]  = '{0, 3'd5, 64'd100, 64'd7, 64'd14, 34};
    vt[7]  = '{0, 3'd7, 64'd100, 64'd7, 64'd2, 34};
    vt[8]  = '{0, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF, 1};
    vt[9]  = '{0, 3'd6, 64'd5, 64'd0, 64'd5, 1};
    vt[10] = '{0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
    vt[11] = '{0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vt[12] = '{1, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vt[13] = '{1, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
    vt[14] = '{1, 3'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
    vt[15] = '{1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vt[16] = '{1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vt[17] = '{1, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vt[18] = '{1, 3'd5, 64'd100, 64'd7, 64'd14, 66};
    vt[19] = '{1, 3'd7, 64'd100, 64'd7, 64'd2, 66};
    vt[20] = '{1, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[21] = '{1, 3'd6, 64'd5, 64'd0, 64'd5, 1};
    vt[22] = '{1, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vt[23] = '{1, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    for (int i = 0; i < 24; i++) begin
      run_op(vt[i].w, vt[i].op, vt[i].a, vt[i].b, r, lat);
      chk($sformatf("vec%0d_res", i), r, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
    end
    for (int i = 0; i < 60; i++) begin
      w = i >= 30;
      o = 3'($urandom_range(0, 7));
      x = rnd(w);
      y = rnd(w);
      run_op(w, o, x, y, r, lat);
      chk($sformatf("rnd%0d_op%0d_res", i, o), r, model(w, o, x, y));
      chk($sformatf("rnd%0d_op%0d_lat", i, o), 64'(lat), 64'(model_lat(w, o, x, y)));
    end
    op = 3'd5;
    a = 64'd100;
    b = 64'd7;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 200) begin
      if (lat == 5) begin
        op = 3'd0;
        a = 64'd3;
        b = 64'd3;
        start32 = 1'b1;
      end else start32 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start32 = 1'b1;
    chk("ign_calc_res", {32'b0, res32}, 64'd14);
    chk("ign_calc_lat", 64'(lat), 64'd34);
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("ign_done_busy", 64'(busy32), 64'd0);
    chk("ign_done_res", {32'b0, res32}, 64'd14);
    op = 3'd4;
    a = 64'hFFFF_FFF9;
    b = 64'd2;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 64'(busy32), 64'd0);
    chk("kill_done", 64'(done32), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    chk("kill_no_done", 64'(seen), 64'd0);
    chk("kill_res", {32'b0, res32}, 64'd14);
    op = 3'd0;
    a = 64'd3;
    b = 64'd3;
    start32 = 1'b1;
    kill = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    kill = 1'b0;
    chk("kill_start_busy", 64'(busy32), 64'd0);
    chk("kill_start_res", {32'b0, res32}, 64'd14);
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("kdone_pulse", 64'(done32), 64'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kdone_busy", 64'(busy32), 64'd0);
    chk("kdone_done", 64'(done32), 64'd0);
    chk("kdone_res", {32'b0, res32}, 64'd9);
    op = 3'd0;
    a = 64'd5;
    b = 64'd6;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy32), 64'd0);
    chk("midrst_done", 64'(done32), 64'd0);
    chk("midrst_res", {32'b0, res32}, 64'd0);
    run_op(1'b0, 3'd0, 64'd5, 64'd6, r, lat);
    chk("after_rst_res", r, 64'd30);
    chk("after_rst_lat", 64'(lat), 64'd34);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative, parametrised RV32M/RV64M multiply/divide unit. Replaces single-cycle combinational `*`, `/` and `%` datapaths with a shift-add multiplier and a restoring divider, each taking one bit per cycle. It sits beside the main ALU in EX. The pipeline stalls while `busy`=1 and captures `result` on `done`. Divide-by-zero and signed-overflow results follow the RISC-V specification exactly; no high-Z outputs.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when busy=0
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand, sampled on accept
b  input  XLEN  rs2 operand, sampled on accept
kill  input  1  pipeline flush; aborts the in-flight operation
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; result valid this cycle and held afterwards
result  output  XLEN  registered result

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation): state=IDLE; busy=0; done=0; result=0; internal registers cleared.
- States: IDLE, CALC, ADJ, DONE.
- IDLE, start=1 → latch op, a, b. Compute magnitudes:
  - |a| for signed ops (MUL, MULH, MULHSU, DIV, REM).
  - |b| for MUL, MULH, DIV, REM. MULHSU treats b as unsigned.
  - neg_res: MUL/MULH/MULHSU = sign(a)^sign(b); DIV = sign(a)^sign(b); REM = sign(a).
  - counter=0.
  - Next state is CALC, except the fast paths, which go straight to DONE with result loaded:
    - b==0: DIV/DIVU → all ones; REM/REMU → a.
    - DIV/REM with a==1<<(XLEN-1) and b==all ones: DIV → a; REM → 0.
- CALC: exactly XLEN cycles, counter increments each cycle.
  - Multiply: 2*XLEN-bit accumulator; shift-add, LSB of multiplier first.
  - Divide: restoring. Shift the remainder left, bring in the next dividend MSB, trial-subtract the divisor. Quotient bit = no-borrow.
  - On counter==XLEN-1 → ADJ.
- ADJ: one cycle. Two's-complement negate the 2*XLEN product or the quotient when neg_res=1; negate the remainder when neg_res=1 for REM. Select the result:
  - MUL → product[XLEN-1:0]
  - MULH/MULHSU/MULHU → product[2*XLEN-1:XLEN]
  - DIV/DIVU → quotient
  - REM/REMU → remainder
  - result is registered at the end of ADJ. Next state DONE.
- DONE: done=1 for exactly this cycle; busy=1; next state IDLE.
- Latency, with start accepted in cycle 0:
  - normal path: done in cycle XLEN+2 (34 for XLEN=32).
  - fast path: done in cycle 1.
  - Back-to-back: the next start can be accepted in the cycle after DONE.
- start while busy=1 (including in DONE): ignored, no side effects.
- kill=1 in CALC, ADJ or DONE: next state IDLE. No done pulse. result keeps its previous value.
  - kill in DONE: done is still 1 that cycle, since done is a registered state decode.
  - kill=1 with start=1 in IDLE: start is not accepted; kill wins.
- rst has priority over kill; kill has priority over start.
- result changes only at the end of ADJ or on a fast-path accept. It is stable between done pulses.
- Arithmetic widths: multiply accumulator 2*XLEN bits; divider remainder XLEN+1 bits. All arithmetic is unsigned on magnitudes; signs are applied in ADJ.

Test Plan:
- XLEN=32, MUL a=7 b=0xFFFFFFFD (−3) → result=0xFFFFFFEB; done exactly 34 cycles after start; busy high cycles 1–34.
- MULH a=b=0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7) b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU a=100 b=7 → 14. REMU same operands → 2.
- DIVU a=5 b=0 → 0xFFFFFFFF with done in cycle 1. REM a=5 b=0 → 5. DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000, cycle 1. REM same operands → 0.
- Start DIV, assert kill in cycle 10 → IDLE in cycle 11, no done, result unchanged. A second start during the first op's CALC is ignored.
- Assert rst in cycle 20 of a MUL → busy=0, done=0, result=0 next cycle. A fresh MUL then completes correctly. Repeat the div/mul vectors with XLEN=64 (latency 66).
